onehot_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource between 8 requesters.
- Drives a registered one-hot grant vector plus its 3-bit binary index, so downstream muxes can select on either form.
- Sits in front of the shared datapath in place of a free-running one-hot source.
- Enforces a one-cycle dead gap between owners and a maximum hold time per grant.

---
 rtl/onehot_rr_arbiter.sv | 106 ++++++++++
 tb/tb_onehot_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot and binary grant outputs.
// Each ownership ends in exactly one dead GAP cycle; it ends on release or after MAX_HOLD cycles.
module onehot_rr_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt, timeout_nxt;
  logic [IDX_W-1:0] win_idx, pos;

  // Scan from the far end back toward ptr so the closest set bit (in rotation order) is written last.
  always_comb begin
    win_idx = '0;
    pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = ptr + IDX_W'(k);
      if (req[pos]) win_idx = pos;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_nxt   = win_idx;
          valid_nxt = 1'b1;
          hold_nxt  = 8'd0;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx] || hold_cnt == HOLD_LAST) begin
          state_nxt   = GAP;
          ptr_nxt     = gnt_idx + IDX_W'(1);
          gnt_nxt     = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          hold_nxt    = 8'd0;
          // A still-requesting owner can only be leaving because the hold limit hit.
          timeout_nxt = req[gnt_idx];
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= 8'd0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed and random checks of onehot_rr_arbiter against an owner/ptr reference model.
module tb_onehot_rr_arbiter;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  int tests = 0;
  int fails = 0;

  // Reference model: current owner (-1 = none), cycles owned so far, search start, timeout pulse.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  // Independent run-length tracking for the MAX_HOLD invariant.
  int run_len = 0;
  bit prev_valid = 1'b0;
  int prev_idx = 0;

  onehot_rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_to = 1'b0;
    run_len = 0; prev_valid = 1'b0; prev_idx = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    bit found;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_held == MAX_HOLD) begin
        m_to    = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && r[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("encoding", {31'd0, gnt_valid ? (gnt == (N'(1) << gnt_idx)) : (gnt == '0 && gnt_idx == '0)}, 32'd1);
    chk("timeout_vs_valid", {31'd0, timeout & gnt_valid}, 32'd0);
    if (gnt_valid) begin
      run_len = (prev_valid && prev_idx == int'(gnt_idx)) ? run_len + 1 : 1;
      chk("hold_limit", {31'd0, run_len <= MAX_HOLD}, 32'd1);
    end
    prev_valid = gnt_valid;
    prev_idx   = int'(gnt_idx);
  endtask

  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Keeps r applied while the current owner holds; returns its grant length.
  task automatic hold_run(input logic [N-1:0] r, output int cnt);
    cnt = 1;
    for (int i = 0; i < 40 && gnt_valid; i++) begin
      cycle(r);
      if (gnt_valid) cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [N-1:0] rr;

    // Reset state, sampled at a clock edge with rst held high.
    @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, release, gap, idle.
    cycle(8'h00);
    cycle(8'h08);
    chk("single_gnt", 32'(gnt), 32'h08);
    chk("single_idx", 32'(gnt_idx), 32'd3);
    cycle(8'h00);
    chk("single_gap", 32'(gnt_valid), 32'd0);
    cycle(8'h00);
    chk("single_idle", 32'(gnt), 32'd0);

    // Asynchronous reset mid-grant, then ptr must be back at 0.
    cycle(8'h08);
    chk("pre_rst_idx", 32'(gnt_idx), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_valid", 32'(gnt_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(8'h81);
    chk("ptr_after_rst", 32'(gnt_idx), 32'd0);

    // Round robin with all requesting; each owner drops req once after 2 cycles.
    do_reset();
    cycle(8'hFF);
    for (int i = 0; i < 9; i++) begin
      chk("rr_order", 32'(gnt_idx), 32'(i % N));
      cycle(8'hFF);
      cycle(8'hFF & ~(N'(1) << (i % N)));
      chk("rr_gap", 32'(gnt_valid), 32'd0);
      cycle(8'hFF);
    end

    // Pointer wrap and skip: ptr=6 after an owner-5 grant.
    do_reset();
    cycle(8'h20);
    chk("wrap_owner5", 32'(gnt_idx), 32'd5);
    cycle(8'h00);
    cycle(8'h00);
    cycle(8'h05);
    chk("wrap_first", 32'(gnt_idx), 32'd0);
    cycle(8'h04);
    cycle(8'h05);
    chk("wrap_second", 32'(gnt_idx), 32'd2);
    cycle(8'h01);
    cycle(8'h05);
    chk("wrap_third", 32'(gnt_idx), 32'd0);

    // Timeout alternation between requesters 0 and 5.
    do_reset();
    cycle(8'h21);
    chk("to_owner0", 32'(gnt_idx), 32'd0);
    hold_run(8'h21, cnt);
    chk("to_len0", 32'(cnt), 32'(MAX_HOLD));
    chk("to_pulse0", 32'(timeout), 32'd1);
    cycle(8'h21);
    chk("to_owner5", 32'(gnt_idx), 32'd5);
    hold_run(8'h21, cnt);
    chk("to_len5", 32'(cnt), 32'(MAX_HOLD));
    chk("to_pulse5", 32'(timeout), 32'd1);
    cycle(8'h21);
    chk("to_owner0_again", 32'(gnt_idx), 32'd0);

    // Sole re-requester keeps getting re-granted after each timeout.
    do_reset();
    cycle(8'h10);
    for (int i = 0; i < 3; i++) begin
      chk("sole_idx", 32'(gnt_idx), 32'd4);
      hold_run(8'h10, cnt);
      chk("sole_len", 32'(cnt), 32'(MAX_HOLD));
      chk("sole_pulse", 32'(timeout), 32'd1);
      cycle(8'h10);
    end

    // Random traffic: bits flip with probability 1/8 per cycle so grants run long.
    do_reset();
    rr = N'($urandom);
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) rr[b] = ~rr[b];
      cycle(rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
